// File: rtl/cla4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cla4_seq_ctrl
//
// Purpose:
//   Sequential N-bit adder/subtractor (N = 4*WORDS) built around one 4-bit
//   carry-lookahead slice. An accepted request is processed one nibble per
//   clock, LSB slice first. The result is then held until the consumer takes
//   it. Subtraction is A + ~B + 1, so it reuses the same adder path.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   request carries valid operands
//   in_ready   out  block is idle and can accept a request
//   a, b       in   N-bit operands
//   ci         in   carry-in for addition (ignored when sub=1)
//   sub        in   0 = a+b+ci, 1 = a-b
//   out_valid  out  result in s/co/ovf is valid
//   out_ready  in   consumer accepts the result
//   s          out  N-bit sum/difference
//   co         out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  two's-complement signed overflow
//   busy       out  an operation is in flight or waiting for hand-off
// ---------------------------------------------------------------------------
module cla4_seq_ctrl #(
    parameter int WORDS = 4,
    localparam int N  = 4 * WORDS,
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         co,
    output logic         ovf,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_opA;
    logic [N-1:0]   r_opB;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_s;
    logic           r_co;
    logic           r_ovf;

    logic [CW+1:0]  w_base;
    logic [3:0]     w_sa;
    logic [3:0]     w_sb;
    logic [3:0]     w_g;
    logic [3:0]     w_p;
    logic [4:0]     w_c;
    logic [3:0]     w_sum;
    logic           w_last;

    // The counter times four is the bit offset of the nibble being worked on.
    assign w_base = {r_cnt, 2'b00};
    assign w_sa   = r_opA[w_base +: 4];
    assign w_sb   = r_opB[w_base +: 4];
    assign w_last = (r_cnt == CW'(WORDS - 1));

    // One 4-bit carry-lookahead slice. Each internal carry is expanded
    // directly from the slice carry-in rather than rippled, so every carry
    // is two logic levels from g/p.
    always_comb begin
        w_g    = w_sa & w_sb;
        w_p    = w_sa ^ w_sb;
        w_c    = '0;
        w_c[0] = r_carry;
        w_c[1] = w_g[0]
               | (w_p[0] & r_carry);
        w_c[2] = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c[4] = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_sum  = w_p ^ w_c[3:0];
    end

    // Control FSM and datapath registers. In IDLE a request is latched, with
    // B pre-inverted and the carry forced to 1 for subtraction. Each RUN cycle
    // writes one nibble of the result and passes the slice carry to the next.
    // The last slice also latches co and ovf, where ovf compares the carries
    // into and out of the MSB. The counter stops on the last slice so it
    // never wraps mid-operation. DONE holds the result until it is taken.
    // Results persist through IDLE and are only overwritten by the next RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_opA   <= '0;
            r_opB   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_opA   <= a;
                        r_opB   <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : ci;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s[w_base +: 4] <= w_sum;
                    r_carry          <= w_c[4];
                    if (w_last) begin
                        r_co    <= w_c[4];
                        r_ovf   <= w_c[4] ^ w_c[3];
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags are decoded straight from the state register.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign s         = r_s;
    assign co        = r_co;
    assign ovf       = r_ovf;

endmodule
